// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the S2MM test packet generator.
// No logic of its own: state encoding, last-beat keep lookup and LFSR seed.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } gen_state_e;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  // Byte enables of the final beat, indexed by byte length modulo 4.
  function automatic logic [3:0] last_keep(input logic [1:0] len);
    case (len)
      2'd1:    last_keep = 4'b0001;
      2'd2:    last_keep = 4'b0011;
      2'd3:    last_keep = 4'b0111;
      default: last_keep = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/axis_gen_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), advances when en is high.
// One-cycle update latency; no backpressure.
module axis_gen_lfsr
  import axis_gen_pkg::*;
(
  input  logic        axi_aclk,
  input  logic        axi_resetn,
  input  logic        en,
  output logic [15:0] lfsr
);

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      lfsr <= LFSR_INIT;
    end else if (en) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

endmodule

// File: rtl/axis_s2mm_pkt_gen.sv
// AXI4-Stream packet source: start -> one packet of byte_len bytes, beat k = seed + k, tvalid one cycle after start.
// Beats hold while tready is low; optional random bubbles when AXIS_GEN_THROTTLE_EN is defined.
module axis_s2mm_pkt_gen
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      byte_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] s_axis_s2mm_tdata,
  output logic [3:0]            s_axis_s2mm_tkeep,
  output logic                  s_axis_s2mm_tvalid,
  input  logic                  s_axis_s2mm_tready,
  output logic                  s_axis_s2mm_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      tx_beats
);

  gen_state_e            state_q, state_d;
  logic                  vld_q, vld_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      last_q, last_d;
  logic [1:0]            len_lo_q, len_lo_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [LEN_W-1:0]      tx_q, tx_d;
  logic                  gate;
  logic                  is_last;
  logic                  hs;
  logic [3:0]            keep_cur;

`ifdef AXIS_GEN_THROTTLE_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  axis_gen_lfsr u_lfsr (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .en         (1'b1),
    .lfsr       (lfsr)
  );

  assign gate        = lfsr[0];
  assign unused_lfsr = ^lfsr[15:1];
`else
  assign gate = 1'b1;
`endif

  assign is_last  = (idx_q == last_q);
  assign hs       = vld_q & s_axis_s2mm_tready;
  assign keep_cur = is_last ? last_keep(len_lo_q) : 4'b1111;

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q  <= IDLE;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
      len_lo_q <= '0;
      dat_q    <= '0;
      tx_q     <= '0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      len_lo_q <= len_lo_d;
      dat_q    <= dat_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    idx_d    = idx_q;
    last_d   = last_q;
    len_lo_d = len_lo_q;
    dat_d    = dat_q;
    tx_d     = tx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d = '0;
          if (byte_len == '0) begin
            state_d = DONE;
          end else begin
            state_d  = SEND;
            idx_d    = '0;
            last_d   = (byte_len - LEN_W'(1)) >> 2;
            len_lo_d = byte_len[1:0];
            dat_d    = seed;
            vld_d    = gate;
          end
        end
      end
      SEND: begin
        if (hs) begin
          tx_d = tx_q + LEN_W'(1);
          if (is_last) begin
            state_d = DONE;
            vld_d   = 1'b0;
          end else begin
            idx_d = idx_q + LEN_W'(1);
            dat_d = dat_q + DATA_WIDTH'(1);
            vld_d = gate;
          end
        end else if (!vld_q) begin
          // A presented beat is held until accepted; only an empty slot may be filled.
          vld_d = gate;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    s_axis_s2mm_tdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (vld_q && keep_cur[i]) begin
        s_axis_s2mm_tdata[8*i +: 8] = dat_q[8*i +: 8];
      end
    end
  end

  assign s_axis_s2mm_tvalid = vld_q;
  assign s_axis_s2mm_tkeep  = vld_q ? keep_cur : 4'b0000;
  assign s_axis_s2mm_tlast  = vld_q & is_last;
  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign tx_beats           = tx_q;

endmodule
